// File: rtl/mitchell_mult_pipe.sv
// Three-stage elastic Mitchell logarithmic multiplier with a valid/ready handshake and an accepted-op counter.
// Build option: define MITCHELL_ROUND_EN to round the final right shift half-up instead of truncating it.
module mitchell_mult_pipe #(
    parameter int W     = 24,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     operand_a,
    input  logic [W-1:0]     operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic [CNT_W-1:0] op_count
);
    localparam int F  = W - 1;
    localparam int KW = $clog2(W);
    localparam int EW = $clog2(2 * W);
    localparam logic [EW-1:0]  F_E   = EW'(F);
    localparam logic [2*W-1:0] ONE_P = 1;

    function automatic logic [KW-1:0] lead_one(input logic [W-1:0] x);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) k = KW'(i);
        end
        return k;
    endfunction

    function automatic logic [F-1:0] frac_of(input logic [W-1:0] x, input logic [KW-1:0] k);
        logic [W-1:0] sh;
        sh = x << (KW'(F) - k);
        return sh[F-1:0];
    endfunction

    // A word moves on valid & ready; each stage loads when empty or when its
    // contents move on in the same cycle, so ready ripples back from out_ready.
    logic rdy1, rdy2, rdy3;

    logic          v1, z1;
    logic [KW-1:0] ka1, kb1;
    logic [F-1:0]  fa1, fb1;

    logic          v2, z2;
    logic [EW-1:0] e2;
    logic [W-1:0]  m2;

    logic           v3;
    logic [2*W-1:0] p3;

    logic [W-1:0]   s_sum;
    logic [EW-1:0]  e_nxt;
    logic [W-1:0]   m_nxt;
    logic [2*W-1:0] m_wide;
    logic [2*W-1:0] p_nxt;

    assign rdy3      = !v3 || out_ready;
    assign rdy2      = !v2 || rdy3;
    assign rdy1      = !v1 || rdy2;
    assign in_ready  = rdy1;
    assign out_valid = v3;
    assign product   = p3;

    always_comb begin
        s_sum = {1'b0, fa1} + {1'b0, fb1};
        e_nxt = EW'(ka1) + EW'(kb1) + EW'(s_sum[F]);
        m_nxt = {1'b1, s_sum[F-1:0]};
    end

    always_comb begin
        m_wide = {{W{1'b0}}, m2};
        p_nxt  = '0;
        if (z2) begin
            p_nxt = '0;
        end else if (e2 >= F_E) begin
            p_nxt = m_wide << (e2 - F_E);
        end else begin
`ifdef MITCHELL_ROUND_EN
            p_nxt = (m_wide + (ONE_P << (F_E - e2 - EW'(1)))) >> (F_E - e2);
`else
            p_nxt = m_wide >> (F_E - e2);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            z1       <= 1'b0;
            ka1      <= '0;
            kb1      <= '0;
            fa1      <= '0;
            fb1      <= '0;
            v2       <= 1'b0;
            z2       <= 1'b0;
            e2       <= '0;
            m2       <= '0;
            v3       <= 1'b0;
            p3       <= '0;
            op_count <= '0;
        end else begin
            if (rdy1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    z1  <= (operand_a == '0) || (operand_b == '0);
                    ka1 <= lead_one(operand_a);
                    kb1 <= lead_one(operand_b);
                    fa1 <= frac_of(operand_a, lead_one(operand_a));
                    fb1 <= frac_of(operand_b, lead_one(operand_b));
                end
            end
            if (rdy2) begin
                v2 <= v1;
                if (v1) begin
                    z2 <= z1;
                    e2 <= e_nxt;
                    m2 <= m_nxt;
                end
            end
            if (rdy3) begin
                v3 <= v2;
                if (v2) p3 <= p_nxt;
            end
            if (in_valid && rdy1) op_count <= op_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mitchell_mult_pipe.sv
// Bench for mitchell_mult_pipe: a W=24 instance and a W=8/CNT_W=4 instance against an arithmetic Mitchell model.
// Honours MITCHELL_ROUND_EN the same way the design does.
module tb_mitchell_mult_pipe;
    localparam int WA = 24;
    localparam int CA = 32;
    localparam int WB = 8;
    localparam int CB = 4;
`ifdef MITCHELL_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [WA-1:0]   a_opa, a_opb;
    logic [2*WA-1:0] a_product;
    logic [CA-1:0]   a_op_count;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [WB-1:0]   b_opa, b_opb;
    logic [2*WB-1:0] b_product;
    logic [CB-1:0]   b_op_count;

    mitchell_mult_pipe #(.W(WA), .CNT_W(CA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .operand_a(a_opa), .operand_b(a_opb), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .product(a_product), .op_count(a_op_count)
    );

    mitchell_mult_pipe #(.W(WB), .CNT_W(CB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .operand_a(b_opa), .operand_b(b_opb), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .product(b_product), .op_count(b_op_count)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mitchell product from the log-domain definition, fractions scaled by 2^(w-1).
    function automatic longint unsigned mitchell_model(input longint unsigned x, input longint unsigned y,
                                                       input int w, input bit rnd);
        int f, kx, ky, e;
        longint unsigned fx, fy, one, sum, mant;
        if (x == 0 || y == 0) return 0;
        f  = w - 1;
        kx = 0;
        while ((x >> (kx + 1)) != 0) kx++;
        ky = 0;
        while ((y >> (ky + 1)) != 0) ky++;
        fx  = (x - (64'd1 << kx)) << (f - kx);
        fy  = (y - (64'd1 << ky)) << (f - ky);
        one = 64'd1 << f;
        sum = fx + fy;
        if (sum >= one) begin
            e    = kx + ky + 1;
            mant = sum;
        end else begin
            e    = kx + ky;
            mant = one + sum;
        end
        if (e >= f) return mant << (e - f);
        if (rnd) return (mant + (64'd1 << (f - e - 1))) >> (f - e);
        return mant >> (f - e);
    endfunction

    logic [2*WA-1:0] exp_a_q[$];
    logic [2*WB-1:0] exp_b_q[$];
    int acc_a = 0, acc_b = 0, out_a = 0;

    // Scoreboards: push the model result on every input transfer, pop on every output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_a_q.delete();
            exp_b_q.delete();
            acc_a = 0;
            acc_b = 0;
        end else begin
            if (a_out_valid && a_out_ready) begin
                out_a++;
                if (exp_a_q.size() == 0) check("a_out_unexpected", a_out_valid, 1'b0);
                else check("a_product", a_product, exp_a_q.pop_front());
            end
            if (b_out_valid && b_out_ready) begin
                if (exp_b_q.size() == 0) check("b_out_unexpected", b_out_valid, 1'b0);
                else check("b_product", b_product, exp_b_q.pop_front());
            end
            if (a_in_valid && a_in_ready) begin
                exp_a_q.push_back(mitchell_model(a_opa, a_opb, WA, RND));
                acc_a++;
            end
            if (b_in_valid && b_in_ready) begin
                exp_b_q.push_back(mitchell_model(b_opa, b_opb, WB, RND));
                acc_b++;
            end
        end
    end

    function automatic logic [WA-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return WA'(1);
            2:       return WA'(1) << $urandom_range(0, WA - 1);
            default: return WA'($urandom());
        endcase
    endfunction

    task automatic send_a(input logic [WA-1:0] x, input logic [WA-1:0] y, output int waited);
        bit ok = 1'b0;
        a_opa = x;
        a_opb = y;
        a_in_valid = 1'b1;
        waited = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = a_in_ready;
            @(posedge clk);
            #1;
            if (!ok) waited++;
        end
        a_in_valid = 1'b0;
        check("a_accept", ok, 1'b1);
    endtask

    task automatic send_b(input logic [WB-1:0] x, input logic [WB-1:0] y);
        bit ok = 1'b0;
        b_opa = x;
        b_opb = y;
        b_in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = b_in_ready;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        check("b_accept", ok, 1'b1);
    endtask

    task automatic directed_a(input logic [WA-1:0] x, input logic [WA-1:0] y, input logic [2*WA-1:0] exp);
        int waited;
        int lat = 1;
        bit seen = 1'b0;
        send_a(x, y, waited);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = a_out_valid;
            if (!seen) begin
                @(posedge clk);
                lat++;
            end
        end
        check("a_latency", lat, 3);
        check("a_directed", a_product, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic directed_b(input logic [WB-1:0] x, input logic [WB-1:0] y, input logic [2*WB-1:0] exp);
        bit seen = 1'b0;
        send_b(x, y);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = b_out_valid;
            if (!seen) @(posedge clk);
        end
        check("b_seen", seen, 1'b1);
        check("b_directed", b_product, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++) begin
            @(negedge clk);
            #1;
        end
        check("a_drained", exp_a_q.size(), 0);
        check("b_drained", exp_b_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("a_rst_out_valid", a_out_valid, 1'b0);
        check("a_rst_product", a_product, 0);
        check("a_rst_op_count", a_op_count, 0);
        check("b_rst_out_valid", b_out_valid, 1'b0);
        check("b_rst_product", b_product, 0);
        check("b_rst_op_count", b_op_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int waited;
        int base_out;
        logic [CA-1:0]   base_cnt;
        logic [2*WA-1:0] held;
        bit acc;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_opa = '0; a_opb = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_opa = '0; b_opb = '0;
        apply_reset();
        @(negedge clk);
        check("a_ready_after_reset", a_in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed products, including the exact cases for 1 and powers of two.
        directed_a(24'd5, 24'd6, 48'd28);
        directed_a(24'd3, 24'd3, 48'd8);
        directed_a(24'd1, 24'd12345, 48'd12345);
        directed_a(24'h800000, 24'h800000, 48'h4000_0000_0000);
        directed_a(24'd0, 24'd777, 48'd0);
        directed_b(8'd3, 8'd5, 16'd14);
        directed_b(8'd7, 8'd7, 16'd48);
        directed_b(8'd1, 8'd200, 16'd200);
        directed_b(8'd128, 8'd2, 16'd256);

        // Back-to-back stream: one acceptance and one result per cycle.
        base_out = out_a;
        base_cnt = a_op_count;
        for (int i = 0; i < 100; i++) begin
            send_a(rand_operand(), rand_operand(), waited);
            check("a_b2b_no_wait", waited, 0);
        end
        repeat (3) @(negedge clk);
        #1;
        check("a_b2b_outputs", out_a - base_out, 100);
        check("a_b2b_op_count", a_op_count - base_cnt, 100);
        @(posedge clk);
        #1;

        // Backpressure: three fill the pipe, a fourth waits while the output holds.
        a_out_ready = 1'b0;
        base_cnt = a_op_count;
        for (int i = 0; i < 3; i++) send_a(WA'($urandom()), WA'($urandom()), waited);
        a_opa = WA'($urandom());
        a_opb = WA'($urandom());
        a_in_valid = 1'b1;
        @(negedge clk);
        held = a_product;
        check("a_stall_head", held, exp_a_q[0]);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("a_stall_in_ready", a_in_ready, 1'b0);
            check("a_stall_out_valid", a_out_valid, 1'b1);
            check("a_stall_product", a_product, held);
        end
        check("a_stall_accepted", a_op_count - base_cnt, 3);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        @(negedge clk);
        check("a_release_ready", a_in_ready, 1'b1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        drain();

        // Reset with three operations in flight.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_a(rand_operand(), rand_operand(), waited);
        @(negedge clk);
        check("a_full_before_reset", a_out_valid, 1'b1);
        @(posedge clk);
        #1;
        apply_reset();
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("a_no_stale", a_out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Counter wrap on the 4-bit instance.
        for (int i = 0; i < 17; i++) send_b(WB'($urandom()), WB'($urandom()));
        drain();
        check("b_wrap_op_count", b_op_count, 1);

        // Every 8-bit operand pair.
        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 256; y++) send_b(WB'(x), WB'(y));
        end
        drain();
        check("b_exh_op_count", b_op_count, acc_b % 16);

        // Random valid/ready traffic; a raised valid is held until accepted.
        a_in_valid = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!a_in_valid && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1;
                a_opa = rand_operand();
                a_opb = rand_operand();
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            @(posedge clk);
            #1;
            if (acc) a_in_valid = 1'b0;
        end
        a_in_valid = 1'b0;
        drain();
        check("a_rand_op_count", a_op_count, acc_a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
